// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// The on-tick count is one bit wider than the phase because a slot can be fully lit.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    S_BLANK,
    S_ON,
    S_OFF
  } scan_state_t;

  localparam logic [7:0] AN_OFF     = 8'hFF;
  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam int         SLOT_TICKS = 16;
  localparam int         PHASE_W    = 4;
  localparam int         ON_W       = 5;

  // On-ticks that fit in a slot after the blank interval.
  function automatic logic [ON_W-1:0] clamp_on(input logic [3:0] bright, input int blank_ticks);
    logic [ON_W-1:0] max_on;
    max_on = ON_W'(SLOT_TICKS - blank_ticks);
    return ({1'b0, bright} > max_on) ? max_on : {1'b0, bright};
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Prescaler: emits a one-cycle tick every CLK_DIV enabled cycles.
// Dropping en restarts the count from zero.
module scan_tick_gen #(
  parameter int CLK_DIV = 3125
) (
  input  logic sysCLK,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int                CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge sysCLK) begin
    if (reset || !en) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_MAX) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = en && (cnt_reg == CNT_MAX);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed scan controller for the 8-digit common-anode display, with a
// double-buffered frame that only swaps in at a frame boundary.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int CLK_DIV     = 3125,
  parameter int BLANK_TICKS = 2
) (
  input  logic        sysCLK,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  bright,
  input  logic [7:0]  digit_en,
  input  logic        load_valid,
  input  logic [63:0] load_data,
  output logic        load_ready,
  output logic [7:0]  Cx,
  output logic [7:0]  AN,
  output logic        frame_start,
  output logic [2:0]  digit_idx
);

  localparam logic [2:0]         LAST_DIGIT = 3'(NUM_DIGITS - 1);
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(SLOT_TICKS - 1);
  localparam logic [ON_W-1:0]    BLANK_W    = ON_W'(BLANK_TICKS);

  logic               started_reg;
  logic               scan_en;
  logic               tick;
  logic [PHASE_W-1:0] phase_reg;
  logic [PHASE_W-1:0] phase_next;
  logic [2:0]         digit_reg;
  logic               slot_end;
  logic               frame_end;
  scan_state_t        state_reg;

  logic [ON_W-1:0]    on_cur, on_hold_reg, on_eff;
  logic               den_cur, den_hold_reg, den_eff;

  logic [7:0]         active_mem  [8];
  logic [7:0]         pending_mem [8];
  logic               pending_reg;
  logic               xfer_reg;
  logic               ready_reg;
  logic               accept;

  logic [7:0]         an_dec;
  logic [7:0]         an_reg;
  logic [7:0]         cx_reg;
  logic               frame_start_reg;

  // The prescaler is held for the first enabled cycle so every slot, including
  // the first after reset or re-enable, lines up with its frame_start pulse.
  assign scan_en = enable && started_reg;

  scan_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .sysCLK (sysCLK),
    .reset  (reset),
    .en     (scan_en),
    .tick   (tick)
  );

  assign phase_next = phase_reg + 1'b1;
  assign slot_end   = tick && (phase_reg == LAST_PHASE);
  assign frame_end  = slot_end && (digit_reg == LAST_DIGIT);

  assign on_cur  = clamp_on(bright, BLANK_TICKS);
  assign den_cur = digit_en[digit_reg];
  assign on_eff  = (phase_reg == '0) ? on_cur  : on_hold_reg;
  assign den_eff = (phase_reg == '0) ? den_cur : den_hold_reg;

  always_ff @(posedge sysCLK) begin
    if (reset || !enable) begin
      started_reg     <= 1'b0;
      frame_start_reg <= 1'b0;
      phase_reg       <= '0;
      digit_reg       <= '0;
    end else begin
      started_reg     <= 1'b1;
      frame_start_reg <= !started_reg || frame_end;
      if (tick) begin
        phase_reg <= phase_next;
      end
      if (slot_end) begin
        digit_reg <= (digit_reg == LAST_DIGIT) ? 3'd0 : digit_reg + 3'd1;
      end
    end
  end

  // Brightness and digit enable are captured throughout phase 0 and frozen after.
  always_ff @(posedge sysCLK) begin
    if (reset) begin
      on_hold_reg  <= '0;
      den_hold_reg <= 1'b0;
    end else if (phase_reg == '0) begin
      on_hold_reg  <= on_cur;
      den_hold_reg <= den_cur;
    end
  end

  always_ff @(posedge sysCLK) begin
    if (reset || !enable) begin
      state_reg <= S_BLANK;
    end else if (tick) begin
      unique case (state_reg)
        S_BLANK: begin
          if ({1'b0, phase_next} >= BLANK_W) begin
            state_reg <= (on_eff != '0) ? S_ON : S_OFF;
          end
        end
        S_ON: begin
          if (phase_next == '0) begin
            state_reg <= S_BLANK;
          end else if ({1'b0, phase_next} >= BLANK_W + on_eff) begin
            state_reg <= S_OFF;
          end
        end
        S_OFF: begin
          if (phase_next == '0) begin
            state_reg <= S_BLANK;
          end
        end
        default: state_reg <= S_BLANK;
      endcase
    end
  end

  // Anode decode; digits beyond NUM_DIGITS never light.
  for (genvar gi = 0; gi < 8; gi++) begin : g_an
    if (gi < NUM_DIGITS) begin : g_used
      assign an_dec[gi] = (digit_reg != 3'(gi));
    end else begin : g_unused
      assign an_dec[gi] = 1'b1;
    end
  end

  always_ff @(posedge sysCLK) begin
    if (reset || !enable) begin
      an_reg <= AN_OFF;
      cx_reg <= SEG_BLANK;
    end else if (state_reg == S_ON && den_eff) begin
      an_reg <= an_dec;
      cx_reg <= active_mem[digit_reg];
    end else begin
      an_reg <= AN_OFF;
      cx_reg <= SEG_BLANK;
    end
  end

  // Handshake: a frame swap takes one cycle after the boundary, and ready is
  // re-registered from the cleared pending flag, so it rises one cycle later still.
  assign accept = load_valid && ready_reg;

  always_ff @(posedge sysCLK) begin
    if (reset) begin
      pending_reg <= 1'b0;
      xfer_reg    <= 1'b0;
      ready_reg   <= 1'b1;
    end else begin
      xfer_reg <= pending_reg && !xfer_reg && (frame_end || !enable);
      if (accept) begin
        pending_reg <= 1'b1;
        ready_reg   <= 1'b0;
      end else begin
        ready_reg <= !pending_reg;
        if (xfer_reg) begin
          pending_reg <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge sysCLK) begin
    for (int k = 0; k < 8; k++) begin
      if (reset) begin
        pending_mem[k] <= SEG_BLANK;
        active_mem[k]  <= SEG_BLANK;
      end else begin
        if (accept) begin
          pending_mem[k] <= load_data[8*k +: 8];
        end
        if (xfer_reg) begin
          active_mem[k] <= pending_mem[k];
        end
      end
    end
  end

  assign load_ready  = ready_reg;
  assign AN          = an_reg;
  assign Cx          = cx_reg;
  assign frame_start = frame_start_reg;
  assign digit_idx   = digit_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: expected per-slot display records are
// queued when stimulus is applied and compared as each scanned slot completes.
module tb_seg_scan_ctrl;

  localparam int TB_CLK_DIV = 4;
  localparam int TB_BLANK   = 2;
  localparam int ON_MAX     = 16 - TB_BLANK;
  localparam int SLOT_CYC   = 16 * TB_CLK_DIV;
  localparam int FRAME_CYC  = 8 * SLOT_CYC;
  localparam int LEAD_POS   = TB_BLANK * TB_CLK_DIV + 1;

  logic        sysCLK = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  bright;
  logic [7:0]  digit_en;
  logic        load_valid;
  logic [63:0] load_data;
  logic        load_ready;
  logic [7:0]  Cx;
  logic [7:0]  AN;
  logic        frame_start;
  logic [2:0]  digit_idx;

  always #5 sysCLK = ~sysCLK;

  seg_scan_ctrl #(
    .NUM_DIGITS  (8),
    .CLK_DIV     (TB_CLK_DIV),
    .BLANK_TICKS (TB_BLANK)
  ) dut (
    .sysCLK      (sysCLK),
    .reset       (reset),
    .enable      (enable),
    .bright      (bright),
    .digit_en    (digit_en),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .Cx          (Cx),
    .AN          (AN),
    .frame_start (frame_start),
    .digit_idx   (digit_idx)
  );

  typedef struct {
    logic [7:0] an;
    logic [7:0] cx;
    int         low;
  } slot_exp_t;

  slot_exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int ready_rise_pos;
  int cx_lit_before;

  localparam logic [63:0] F_BLANK = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] F1      = 64'h00_11_22_33_44_55_66_77;
  localparam logic [63:0] F2      = 64'hC0_F9_A4_B0_99_92_82_F8;
  localparam logic [63:0] F3      = 64'h5A_5A_5A_5A_5A_5A_5A_5A;
  localparam logic [63:0] F4      = 64'h12_34_56_78_9A_BC_DE_F0;

  task automatic push_frame(input logic [3:0] br, input logic [7:0] en, input logic [63:0] frame);
    int        on_ticks;
    slot_exp_t e;
    on_ticks = (int'(br) > ON_MAX) ? ON_MAX : int'(br);
    for (int k = 0; k < 8; k++) begin
      e.low = en[k] ? on_ticks * TB_CLK_DIV : 0;
      e.an  = (e.low > 0) ? ~(8'd1 << k) : 8'hFF;
      e.cx  = (e.low > 0) ? frame[8*k +: 8] : 8'hFF;
      exp_q.push_back(e);
    end
  endtask

  // Waits (bounded) for frame_start, counting lit segments seen on the way.
  task automatic wait_fs(input string tag);
    int n;
    n = 0;
    cx_lit_before = 0;
    while (frame_start !== 1'b1 && n < 3 * FRAME_CYC) begin
      if (Cx !== 8'hFF) cx_lit_before++;
      @(negedge sysCLK);
      n++;
    end
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL %s_fs_timeout: frame_start=%b after %0d cycles, required 1", tag, frame_start, n);
    end
  endtask

  // Observes one full frame from frame_start and compares each slot to the queue.
  task automatic check_frame(input string tag);
    int         fs_pos, fs_count, pos;
    int         low_cnt, first_low, glitch;
    logic [7:0] an_low, cx_low;
    logic [2:0] idx_mid;
    slot_exp_t  e;
    wait_fs(tag);
    ready_rise_pos = (load_ready === 1'b1) ? 0 : -1;
    fs_pos   = -1;
    fs_count = 0;
    for (int s = 0; s < 8; s++) begin
      low_cnt = 0; first_low = 0; glitch = 0;
      an_low = 8'hFF; cx_low = 8'hFF; idx_mid = 3'bxxx;
      for (int o = 1; o <= SLOT_CYC; o++) begin
        @(negedge sysCLK);
        pos = s * SLOT_CYC + o;
        if (frame_start === 1'b1) begin fs_count++; fs_pos = pos; end
        if (ready_rise_pos < 0 && load_ready === 1'b1) ready_rise_pos = pos;
        if (o == SLOT_CYC / 2) idx_mid = digit_idx;
        if (AN !== 8'hFF) begin
          if (low_cnt == 0) begin first_low = o; an_low = AN; cx_low = Cx; end
          else if (AN !== an_low || Cx !== cx_low) glitch++;
          low_cnt++;
        end else if (Cx !== 8'hFF) begin
          glitch++;
        end
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s_queue_empty: slot %0d observed with no expectation queued", tag, s);
        continue;
      end
      e = exp_q.pop_front();
      checks++;
      if (low_cnt !== e.low) begin
        errors++;
        $display("FAIL %s_low_cycles: slot %0d anode low %0d cycles, required %0d", tag, s, low_cnt, e.low);
      end
      checks++;
      if (an_low !== e.an) begin
        errors++;
        $display("FAIL %s_anode: slot %0d AN=%h, required %h", tag, s, an_low, e.an);
      end
      checks++;
      if (cx_low !== e.cx) begin
        errors++;
        $display("FAIL %s_segments: slot %0d Cx=%h, required %h", tag, s, cx_low, e.cx);
      end
      checks++;
      if (first_low !== ((e.low > 0) ? LEAD_POS : 0)) begin
        errors++;
        $display("FAIL %s_blank_lead: slot %0d first low at %0d, required %0d", tag, s, first_low,
                 (e.low > 0) ? LEAD_POS : 0);
      end
      checks++;
      if (idx_mid !== 3'(s)) begin
        errors++;
        $display("FAIL %s_digit_idx: slot %0d digit_idx=%0d, required %0d", tag, s, idx_mid, s);
      end
      checks++;
      if (glitch !== 0) begin
        errors++;
        $display("FAIL %s_glitch: slot %0d %0d inconsistent cycles, required 0", tag, s, glitch);
      end
    end
    checks++;
    if (fs_count !== 1 || fs_pos !== FRAME_CYC) begin
      errors++;
      $display("FAIL %s_frame_period: frame_start seen %0d times, last at %0d, required once at %0d",
               tag, fs_count, fs_pos, FRAME_CYC);
    end
    $display("frame %s: 8 slots compared, queue depth now %0d", tag, exp_q.size());
  endtask

  task automatic send_load(input logic [63:0] data);
    load_valid = 1'b1;
    load_data  = data;
    @(negedge sysCLK);
    load_valid = 1'b0;
    load_data  = '0;
    $display("load offered data=%h", data);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; bright = 4'd15; digit_en = 8'hFF;
    load_valid = 1'b0; load_data = '0;
    repeat (3) @(negedge sysCLK);
    checks++; if (AN !== 8'hFF) begin errors++; $display("FAIL reset_an: AN=%h, required ff", AN); end
    checks++; if (Cx !== 8'hFF) begin errors++; $display("FAIL reset_cx: Cx=%h, required ff", Cx); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: load_ready=%b, required 1", load_ready); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs: frame_start=%b, required 0", frame_start); end
    checks++; if (digit_idx !== 3'd0) begin errors++; $display("FAIL reset_idx: digit_idx=%0d, required 0", digit_idx); end
    reset = 1'b0;
    $display("reset checked");
  endtask

  task automatic test_scan_blank();
    enable = 1'b1;
    push_frame(4'd15, 8'hFF, F_BLANK);
    push_frame(4'd15, 8'hFF, F_BLANK);
    check_frame("scan0");
    check_frame("scan1");
  endtask

  task automatic test_load();
    repeat (100) @(negedge sysCLK);
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL load_ready_before: load_ready=%b, required 1", load_ready); end
    send_load(F1);
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL load_ready_after: load_ready=%b, required 0", load_ready); end
    push_frame(4'd15, 8'hFF, F1);
    check_frame("load");
    checks++; if (cx_lit_before !== 0) begin errors++; $display("FAIL load_early_show: %0d lit cycles before boundary, required 0", cx_lit_before); end
    checks++; if (ready_rise_pos !== 2) begin errors++; $display("FAIL load_ready_rise: rose at %0d after frame_start, required 2", ready_rise_pos); end
  endtask

  task automatic test_bright();
    bright = 4'd3;
    push_frame(4'd3, 8'hFF, F1);
    check_frame("bright3");
    bright = 4'd0;
    push_frame(4'd0, 8'hFF, F1);
    check_frame("bright0");
    bright = 4'd15;
  endtask

  task automatic test_digit_en();
    digit_en = 8'b1111_1011;
    push_frame(4'd15, 8'b1111_1011, F1);
    check_frame("digit_en");
    digit_en = 8'hFF;
  endtask

  task automatic test_second_load();
    repeat (50) @(negedge sysCLK);
    send_load(F2);
    load_valid = 1'b1;
    load_data  = F3;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (load_ready !== 1'b0) begin errors++; $display("FAIL second_load_ready: cycle %0d load_ready=%b, required 0", i, load_ready); end
      @(negedge sysCLK);
    end
    load_valid = 1'b0;
    load_data  = '0;
    push_frame(4'd15, 8'hFF, F2);
    push_frame(4'd15, 8'hFF, F2);
    check_frame("second_load0");
    checks++; if (ready_rise_pos !== 2) begin errors++; $display("FAIL second_ready_rise: rose at %0d after frame_start, required 2", ready_rise_pos); end
    check_frame("second_load1");
  endtask

  task automatic test_disable();
    int n;
    n = 0;
    while (!(digit_idx === 3'd5 && AN !== 8'hFF) && n < 2 * FRAME_CYC) begin
      @(negedge sysCLK);
      n++;
    end
    checks++;
    if (!(digit_idx === 3'd5 && AN !== 8'hFF)) begin
      errors++;
      $display("FAIL disable_reach_digit5: digit_idx=%0d AN=%h, required 5 with anode low", digit_idx, AN);
    end
    enable = 1'b0;
    @(negedge sysCLK);
    checks++; if (AN !== 8'hFF) begin errors++; $display("FAIL disable_an: AN=%h, required ff", AN); end
    checks++; if (Cx !== 8'hFF) begin errors++; $display("FAIL disable_cx: Cx=%h, required ff", Cx); end
    checks++; if (digit_idx !== 3'd0) begin errors++; $display("FAIL disable_idx: digit_idx=%0d, required 0", digit_idx); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL disable_fs: frame_start=%b, required 0", frame_start); end
    repeat (5) @(negedge sysCLK);
    enable = 1'b1;
    @(negedge sysCLK);
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL reenable_fs: frame_start=%b, required 1", frame_start); end
    checks++; if (digit_idx !== 3'd0) begin errors++; $display("FAIL reenable_idx: digit_idx=%0d, required 0", digit_idx); end
    push_frame(4'd15, 8'hFF, F2);
    check_frame("reenable");
  endtask

  task automatic test_reset_mid();
    send_load(F4);
    repeat (200) @(negedge sysCLK);
    reset = 1'b1;
    @(negedge sysCLK);
    checks++; if (AN !== 8'hFF) begin errors++; $display("FAIL midreset_an: AN=%h, required ff", AN); end
    checks++; if (Cx !== 8'hFF) begin errors++; $display("FAIL midreset_cx: Cx=%h, required ff", Cx); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: load_ready=%b, required 1", load_ready); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL midreset_fs: frame_start=%b, required 0", frame_start); end
    checks++; if (digit_idx !== 3'd0) begin errors++; $display("FAIL midreset_idx: digit_idx=%0d, required 0", digit_idx); end
    reset = 1'b0;
    push_frame(4'd15, 8'hFF, F_BLANK);
    push_frame(4'd15, 8'hFF, F_BLANK);
    check_frame("after_reset0");
    check_frame("after_reset1");
  endtask

  initial begin
    test_reset();
    test_scan_blank();
    test_load();
    test_bright();
    test_digit_en();
    test_second_load();
    test_disable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the 8-digit common-anode 7-segment display on the board. It owns the per-digit refresh schedule: one digit slot at a time, anti-ghosting blank interval, brightness duty, and per-digit enable mask. It also accepts a new 8-digit frame through a valid/ready handshake. The frame is double-buffered so an update only takes effect at a frame boundary and never tears. It replaces ad-hoc counter-plus-mux scanning at the top level and drives the active-low Cx/AN pins directly.

Parameters:
NUM_DIGITS, 8, digits scanned per frame (1..8); AN bits at or above NUM_DIGITS are held high.
CLK_DIV, 3125, sysCLK cycles per scan tick (100 MHz -> 32 kHz tick).
BLANK_TICKS, 2, ticks at the start of each slot with all anodes off (0..15).

Ports:
sysCLK  in  1  system clock, all logic on its rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  scan run; low = display blanked, scan counters held
bright  in  4  on-ticks per slot after the blank interval (0 = dark)
digit_en  in  8  per-digit enable; disabled digit keeps its slot, anode off
load_valid  in  1  new frame offered
load_data  in  64  frame; byte k = active-low segment pattern for digit k
load_ready  out  1  controller can accept a frame
Cx  out  8  active-low segment drive (bit 7 = DP)
AN  out  8  active-low anode drive, one-hot-low or all high
frame_start  out  1  one-cycle pulse when digit 0 slot begins
digit_idx  out  3  digit index of current slot

Behaviour:
- Reset values: Cx=8'hFF, AN=8'hFF, load_ready=1, frame_start=0, digit_idx=0, active and pending buffers all 8'hFF, pending flag 0, phase=0, state=S_BLANK, prescaler=0.
- Tick: prescaler counts 0..CLK_DIV-1 while enable=1; tick asserted for one cycle at CLK_DIV-1, then the prescaler wraps to 0.
- Slot = 16 ticks, phase 0..15; phase advances on tick; digit_idx increments at phase 15->0, wrapping NUM_DIGITS-1 -> 0.
- bright and digit_en[digit_idx] are sampled at phase 0 of each slot and held for the slot.
- FSM per slot:
  - S_BLANK while phase < BLANK_TICKS.
  - Then S_ON for min(bright, 16-BLANK_TICKS) ticks.
  - Then S_OFF to phase 15.
  - If the on-count is 0, S_BLANK goes straight to S_OFF.
  - End of slot returns to S_BLANK.
- Outputs are registered, one cycle after the state/phase change.
  - In S_ON with the digit enabled: AN = ~(1<<digit_idx), Cx = active[digit_idx].
  - Otherwise: AN=8'hFF, Cx=8'hFF.
- frame_start pulses the cycle digit_idx becomes 0 at phase 0, including the first slot after reset or re-enable.
- Handshake:
  - load_ready = ~pending.
  - On load_valid & load_ready, load_data is captured into pending, pending<=1, so load_ready falls the next cycle.
  - load_valid without ready is ignored; load_data need not be held.
- Buffer transfer:
  - At the frame boundary (tick at digit NUM_DIGITS-1, phase 15): active<=pending, pending<=0.
  - If enable=0, the transfer happens on the next cycle.
  - The transfer cycle does not accept a new load; ready rises the following cycle.
- enable=0:
  - Prescaler, phase and digit_idx are forced to 0, state=S_BLANK, outputs are all high, frame_start=0.
  - On re-enable, the scan restarts at digit 0, phase 0.
- Reset mid-scan or mid-handshake discards pending and active contents (all blank).

Decomposition:
- Package seg_scan_pkg holds:
  - the state enum (S_BLANK, S_ON, S_OFF);
  - constants AN_OFF=8'hFF, SEG_BLANK=8'hFF and SLOT_TICKS=16;
  - the phase and tick-count widths.
- One sub-module, scan_tick_gen: parameterised prescaler with sysCLK, reset, en inputs and a one-cycle tick output.
- FSM, buffers and output registers stay in seg_scan_ctrl.

Test Plan:
All scenarios use CLK_DIV=4, NUM_DIGITS=8, BLANK_TICKS=2.
- Reset, enable=1, bright=15, digit_en=8'hFF, no load -> AN steps 8'hFE..8'h7F, Cx=8'hFF throughout; frame_start every 512 cycles; anode low exactly 56 cycles per 64-cycle slot.
- Load 64'h00_11_22_33_44_55_66_77 -> load_ready low 1 cycle later. Cx stays FF until the next frame_start; then digit 0 shows 8'h77 and digit 7 shows 8'h00.
- bright=3 -> per slot: 8 cycles blank, 12 cycles anode low, 44 cycles off. bright=0 -> AN stays 8'hFF.
- digit_en=8'b1111_1011 -> digit 2 slot has AN=8'hFF. Slot timing and frame period stay unchanged (512 cycles).
- Second load_valid while pending -> ignored; only the first frame is displayed. load_ready rises 2 cycles after frame_start.
- Drop enable mid-slot at digit 5 -> AN=FF and Cx=FF the next cycle. Re-enable -> frame_start then digit 0. Reset mid-frame -> all outputs at their reset values, load_ready=1.
